// File: rtl/sevseg_pkg.sv
// sevseg_pkg: scan states and active-high segment patterns {g,f,e,d,c,b,a} for the 7-segment scanner
package sevseg_pkg;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_e;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/sevseg_decode.sv
// sevseg_decode: 4-bit digit to active-high 7-segment pattern, dash for non-BCD codes
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[digit_i];
endmodule

// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan: tear-free 3-digit BCD scanner onto a 4-digit 7-segment display
// SEVSEG_ZERO_BLANK_EN enables leading-zero suppression of the hundreds and tens digits.
module bcd_sevenseg_scan
  import sevseg_pkg::*;
#(
  parameter int SCAN_DIV   = 100_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  scan_e state_q, state_d;
  logic [11:0] pend_q, pend_d, shown_q, shown_d;
  logic pvld_q, pvld_d, fd_q;
  logic [6:0] seg_q, seg_d, dec, seg_act;
  logic [3:0] an_q, an_d, an_act, digit;
  logic wrap, bnd, lit;
  sevseg_decode u_dec (.digit_i(digit), .seg_o(dec));
  always_comb begin
    wrap = cnt_q == CW'(SCAN_DIV - 1);
    bnd = wrap && state_q == DIG3;
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    state_d = wrap ? scan_e'(state_q + 2'd1) : state_q;
    pend_d = load ? {hundreds, tens, ones} : pend_q;
    pvld_d = load ? !bnd : (bnd ? 1'b0 : pvld_q);
    // a load coinciding with the frame boundary bypasses pending straight into the new frame
    shown_d = (bnd && load) ? {hundreds, tens, ones} : (bnd && pvld_q) ? pend_q : shown_q;
    digit = state_q == DIG0 ? shown_q[3:0] : state_q == DIG1 ? shown_q[7:4] : shown_q[11:8];
`ifdef SEVSEG_ZERO_BLANK_EN
    lit = state_q == DIG0 ||
          (state_q == DIG1 && shown_q[11:4] != 8'h00) ||
          (state_q == DIG2 && shown_q[11:8] != 4'h0);
`else
    lit = state_q != DIG3;
`endif
    seg_act = lit ? dec : SEG_BLANK;
    an_act = lit ? 4'(1) << state_q : 4'h0;
    seg_d = seg_act ^ {7{ACTIVE_LOW}};
    an_d = an_act ^ {4{ACTIVE_LOW}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      state_q <= DIG0;
      pend_q <= '0;
      shown_q <= '0;
      pvld_q <= 1'b0;
      fd_q <= 1'b0;
      seg_q <= {7{ACTIVE_LOW}};
      an_q <= {4{ACTIVE_LOW}};
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      pend_q <= pend_d;
      shown_q <= shown_d;
      pvld_q <= pvld_d;
      fd_q <= bnd;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign dp = ACTIVE_LOW;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// tb_bcd_sevenseg_scan: directed plus random stimulus checked against a cycle-position display model
module tb_bcd_sevenseg_scan;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [3:0] hundreds = '0, tens = '0, ones = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp, frame_done;
  int total = 0, bad = 0;
  int pos = 0;
  logic [3:0] sh[3], pd[3];
  bit pv = 0;
  bcd_sevenseg_scan #(.SCAN_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
    .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F; default: return 7'h40;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s pos=%0d got=%h exp=%h", tag, pos, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    logic [6:0] es;
    logic [3:0] ea;
    logic ef;
    int st, cn;
    bit lit;
    rst = r; load = ld; hundreds = h; tens = t; ones = o;
    @(posedge clk);
    if (r) begin
      es = 7'h7F; ea = 4'hF; ef = 1'b0; pos = 0; pv = 0;
      sh = '{default: 4'h0}; pd = '{default: 4'h0};
    end else begin
      st = (pos / DIV) % 4;
      cn = pos % DIV;
      lit = st < 3;
`ifdef SEVSEG_ZERO_BLANK_EN
      if (st == 2) lit = sh[2] != 0;
      if (st == 1) lit = sh[2] != 0 || sh[1] != 0;
`endif
      es = ~(lit ? seg_hi(sh[st < 3 ? st : 0]) : 7'h00);
      ea = ~(lit ? 4'(1 << st) : 4'h0);
      ef = st == 3 && cn == DIV - 1;
      if (ld && ef) begin
        sh[2] = h; sh[1] = t; sh[0] = o; pv = 0;
      end else if (ld) begin
        pd[2] = h; pd[1] = t; pd[0] = o; pv = 1;
      end else if (ef && pv) begin
        sh = pd; pv = 0;
      end
      pos++;
    end
    #1;
    chk("seg", seg, es);
    chk("an", {3'b000, an}, {3'b000, ea});
    chk("frame_done", {6'b0, frame_done}, {6'b0, ef});
    chk("dp", {6'b0, dp}, 7'h01);
    load = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 4'h0);
  endtask
  task automatic goto_digit(input int d);
    for (int i = 0; i < 4 * DIV && ((pos / DIV) % 4) != d; i++) idle(1);
  endtask
  initial begin
    sh = '{default: 4'h0};
    pd = '{default: 4'h0};
    repeat (3) step(1, 0, 4'h0, 4'h0, 4'h0);
    idle(1);
    step(0, 1, 4'd2, 4'd5, 4'd5);
    idle(40);
    goto_digit(1);
    step(0, 1, 4'd1, 4'd2, 4'd3);
    idle(40);
    step(0, 1, 4'd1, 4'd2, 4'hA);
    idle(24);
    step(0, 1, 4'd1, 4'd1, 4'd1);
    step(0, 1, 4'd9, 4'd9, 4'd9);
    idle(36);
    step(0, 1, 4'd0, 4'd0, 4'd7);
    idle(36);
    step(0, 1, 4'd0, 4'd4, 4'd0);
    idle(36);
    for (int i = 0; i < 4 * DIV && (pos % (4 * DIV)) != 4 * DIV - 1; i++) idle(1);
    step(0, 1, 4'd4, 4'd5, 4'd6);
    idle(20);
    step(0, 1, 4'd8, 4'd8, 4'd8);
    goto_digit(2);
    step(1, 0, 4'h0, 4'h0, 4'h0);
    idle(36);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) step(1, 0, 4'h0, 4'h0, 4'h0);
      else if ($urandom_range(0, 9) == 0)
        step(0, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else idle(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
